// File: rtl/pe_fc_chain.sv
// Systolic column of NUM_PE fully-connected MAC stages with a double-buffered stationary ifmap.
// Optional macro PE_FC_SAT_EN: per-stage saturating accumulate with a chained overflow flag.
module pe_fc_chain #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned NUM_PE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     signed_mode,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     swap,
  output logic                     swap_done,
  output logic                     swap_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_PE*DATA_W-1:0] in_w,
  input  logic [ACC_W-1:0]         in_psum,
  output logic                     out_valid,
  output logic [ACC_W-1:0]         out_psum,
  output logic                     out_ovf,
  output logic                     busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = $clog2(NUM_PE + 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL} ld_state_e;

  ld_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               act_valid_q, act_valid_d;
  logic               swap_done_q, swap_done_d;
  logic               swap_err_q, swap_err_d;
  logic               ld_ready_q;
  logic               busy_q, busy_d;
  logic               ld_acc, swap_ok, beat_acc;

  logic [DATA_W-1:0]  sh_q  [NUM_PE];
  logic [DATA_W-1:0]  act_q [NUM_PE];

  logic               v_q   [NUM_PE];
  logic [ACC_W-1:0]   ps_q  [NUM_PE];
  logic               sm_q  [NUM_PE];
  logic               ov_q  [NUM_PE];

  logic               v_in  [NUM_PE];
  logic [ACC_W-1:0]   ps_in [NUM_PE];
  logic               sm_in [NUM_PE];
  logic               ov_in [NUM_PE];
  logic [DATA_W-1:0]  w_st  [NUM_PE];
  logic [ACC_W:0]     res   [NUM_PE];

  logic               out_valid_q;
  logic [ACC_W-1:0]   out_psum_q;
  logic               out_ovf_q;

  // One MAC step; returns {overflow, sum}. Product is extended per the beat's signedness.
  function automatic logic [ACC_W:0] mac(input logic [ACC_W-1:0]  acc,
                                         input logic [DATA_W-1:0] w,
                                         input logic [DATA_W-1:0] x,
                                         input logic              sm);
    logic [PROD_W-1:0] we, xe, prod;
    logic [ACC_W-1:0]  pe, r;
    logic              ovf;
`ifdef PE_FC_SAT_EN
    logic [ACC_W:0]    s;
`endif
    if (sm) begin
      we = PROD_W'($signed(w));
      xe = PROD_W'($signed(x));
    end else begin
      we = PROD_W'(w);
      xe = PROD_W'(x);
    end
    prod = we * xe;
    if (sm) pe = ACC_W'($signed(prod));
    else    pe = ACC_W'(prod);
    ovf = 1'b0;
`ifdef PE_FC_SAT_EN
    s = {1'b0, acc} + {1'b0, pe};
    r = s[ACC_W-1:0];
    if (sm) begin
      if ((acc[ACC_W-1] == pe[ACC_W-1]) && (r[ACC_W-1] != acc[ACC_W-1])) begin
        ovf = 1'b1;
        r   = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (s[ACC_W]) begin
      ovf = 1'b1;
      r   = '1;
    end
`else
    r = acc + pe;
`endif
    return {ovf, r};
  endfunction

  // Shadow loader FSM and swap arbitration.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_valid_d = act_valid_q;
    swap_done_d = 1'b0;
    swap_err_d  = 1'b0;
    swap_ok     = 1'b0;
    ld_acc      = ld_valid && (state_q != ST_FULL);
    if (ld_acc) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = (cnt_q == CNT_W'(NUM_PE - 1)) ? ST_FULL : ST_FILLING;
    end
    if (swap) begin
      if ((state_q == ST_FULL) && !busy_q && !in_valid) begin
        swap_ok     = 1'b1;
        state_d     = ST_EMPTY;
        cnt_d       = '0;
        act_valid_d = 1'b1;
        swap_done_d = 1'b1;
      end else begin
        swap_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_ctrl
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= '0;
      act_valid_q <= 1'b0;
      swap_done_q <= 1'b0;
      swap_err_q  <= 1'b0;
      ld_ready_q  <= 1'b1;
      for (int i = 0; i < NUM_PE; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_valid_q <= act_valid_d;
      swap_done_q <= swap_done_d;
      swap_err_q  <= swap_err_d;
      ld_ready_q  <= (state_d != ST_FULL);
      if (ld_acc) begin
        for (int i = 0; i < NUM_PE - 1; i++) sh_q[i] <= sh_q[i+1];
        sh_q[NUM_PE-1] <= ld_data;
      end
      if (swap_ok) begin
        for (int i = 0; i < NUM_PE; i++) act_q[i] <= sh_q[i];
      end
    end
  end

  assign beat_acc = in_valid && act_valid_q;

  // Per-stage inputs; weight slice k passes through a k-deep skew line.
  for (genvar k = 0; k < NUM_PE; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_in[0]  = beat_acc;
      assign ps_in[0] = in_psum;
      assign sm_in[0] = signed_mode;
      assign ov_in[0] = 1'b0;
      assign w_st[0]  = in_w[DATA_W-1:0];
    end else begin : g_body
      logic [DATA_W-1:0] sk_q [k];
      always_ff @(posedge clk or negedge rst_n) begin : p_skew
        if (!rst_n) begin
          for (int d = 0; d < k; d++) sk_q[d] <= '0;
        end else begin
          sk_q[0] <= in_w[k*DATA_W +: DATA_W];
          for (int d = 1; d < k; d++) sk_q[d] <= sk_q[d-1];
        end
      end
      assign v_in[k]  = v_q[k-1];
      assign ps_in[k] = ps_q[k-1];
      assign sm_in[k] = sm_q[k-1];
      assign ov_in[k] = ov_q[k-1];
      assign w_st[k]  = sk_q[k-1];
    end
    assign res[k] = mac(ps_in[k], w_st[k], act_q[k], sm_in[k]);
  end

  always_comb begin
    busy_d = 1'b0;
    for (int k = 0; k < NUM_PE; k++) busy_d = busy_d | v_in[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_pipe
    if (!rst_n) begin
      for (int k = 0; k < NUM_PE; k++) begin
        v_q[k]  <= 1'b0;
        ps_q[k] <= '0;
        sm_q[k] <= 1'b0;
        ov_q[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      out_psum_q  <= '0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_PE; k++) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          ps_q[k] <= res[k][ACC_W-1:0];
          sm_q[k] <= sm_in[k];
          ov_q[k] <= ov_in[k] | res[k][ACC_W];
        end
      end
      out_valid_q <= v_q[NUM_PE-1];
      if (v_q[NUM_PE-1]) begin
        out_psum_q <= ps_q[NUM_PE-1];
        out_ovf_q  <= ov_q[NUM_PE-1];
      end
      busy_q <= busy_d;
    end
  end

  assign ld_ready  = ld_ready_q;
  assign swap_done = swap_done_q;
  assign swap_err  = swap_err_q;
  assign in_ready  = act_valid_q;
  assign out_valid = out_valid_q;
  assign out_psum  = out_psum_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pe_fc_chain.sv
// Scoreboard bench for pe_fc_chain: stimulus pushes expected results and probes, a negedge monitor checks them.
module tb_pe_fc_chain;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned NUM_PE = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     signed_mode = 1'b0;
  logic                     ld_valid = 1'b0;
  logic                     ld_ready;
  logic [DATA_W-1:0]        ld_data = '0;
  logic                     swap = 1'b0;
  logic                     swap_done, swap_err;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [NUM_PE*DATA_W-1:0] in_w = '0;
  logic [ACC_W-1:0]         in_psum = '0;
  logic                     out_valid;
  logic [ACC_W-1:0]         out_psum;
  logic                     out_ovf;
  logic                     busy;

  pe_fc_chain #(.DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_PE(NUM_PE)) dut (
    .clk(clk), .rst_n(rst_n), .signed_mode(signed_mode),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .swap(swap), .swap_done(swap_done), .swap_err(swap_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_psum(in_psum),
    .out_valid(out_valid), .out_psum(out_psum), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ACC_W-1:0] psum;
    logic             ovf;
    int unsigned      at;
    string            name;
  } exp_t;

  typedef enum int {P_OVALID, P_OPSUM, P_OOVF, P_SDONE, P_SERR, P_BUSY, P_INRDY, P_LDRDY, P_SBLEFT} probe_e;

  typedef struct {
    probe_e      sel;
    logic [63:0] exp;
    string       name;
  } probe_t;

  exp_t   sb[$];
  probe_t pq[$];
  exp_t   e;
  probe_t p;
  int     n_total = 0;
  int     n_pass  = 0;

  function automatic void cmp(string nm, logic [63:0] act, logic [63:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
  endfunction

  function automatic logic [63:0] probe_val(probe_e s);
    case (s)
      P_OVALID: return 64'(out_valid);
      P_OPSUM:  return 64'(out_psum);
      P_OOVF:   return 64'(out_ovf);
      P_SDONE:  return 64'(swap_done);
      P_SERR:   return 64'(swap_err);
      P_BUSY:   return 64'(busy);
      P_INRDY:  return 64'(in_ready);
      P_LDRDY:  return 64'(ld_ready);
      default:  return 64'(sb.size());
    endcase
  endfunction

  // Monitor: owns every comparison; reset discards in-flight expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out_valid: got out_psum=0x%0h, want no output", out_psum);
      end else begin
        e = sb.pop_front();
        cmp({e.name, "_psum"}, 64'(out_psum), 64'(e.psum));
        cmp({e.name, "_ovf"}, 64'(out_ovf), 64'(e.ovf));
        cmp({e.name, "_cycle"}, 64'(cyc), 64'(e.at));
      end
    end
    while (pq.size() != 0) begin
      p = pq.pop_front();
      cmp(p.name, probe_val(p.sel), p.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input probe_e s, input logic [63:0] want, input string nm);
    pq.push_back('{sel: s, exp: want, name: nm});
  endtask

  task automatic beat(input logic [31:0] w, input logic [31:0] ps, input logic sm,
                      input logic [31:0] want, input logic want_ovf, input string nm);
    in_valid    = 1'b1;
    in_w        = w;
    in_psum     = ps;
    signed_mode = sm;
    sb.push_back('{psum: want, ovf: want_ovf, at: cyc + 1 + NUM_PE, name: nm});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load4(input logic [31:0] v);
    for (int j = 0; j < 4; j++) begin
      ld_valid = 1'b1;
      ld_data  = v[8*j +: 8];
      tick();
    end
    ld_valid = 1'b0;
    probe(P_LDRDY, 64'd0, "ld_full_not_ready");
  endtask

  task automatic do_swap(input logic ok, input string nm);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    probe(P_SDONE, 64'(ok), {nm, "_done"});
    probe(P_SERR, 64'(!ok), {nm, "_err"});
    tick();
    probe(P_SDONE, 64'd0, {nm, "_done_pulse"});
    probe(P_SERR, 64'd0, {nm, "_err_pulse"});
  endtask

  logic [31:0] t3_exp [8] = '{32'd1020, 32'd2041, 32'd3062, 32'd4083,
                              32'd5104, 32'd6125, 32'd7146, 32'd8167};
  logic [31:0] t4_exp;
  logic        t4_ovf;

  initial begin
`ifdef PE_FC_SAT_EN
    t4_exp = 32'h7FFF_FFFF;
    t4_ovf = 1'b1;
`else
    t4_exp = 32'h8000_01EC;
    t4_ovf = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    probe(P_OVALID, 64'd0, "rst_out_valid");
    probe(P_OPSUM, 64'd0, "rst_out_psum");
    probe(P_OOVF, 64'd0, "rst_out_ovf");
    probe(P_SDONE, 64'd0, "rst_swap_done");
    probe(P_SERR, 64'd0, "rst_swap_err");
    probe(P_BUSY, 64'd0, "rst_busy");
    probe(P_INRDY, 64'd0, "rst_in_ready");
    probe(P_LDRDY, 64'd1, "rst_ld_ready");
    tick();

    // Beat before any swap is dropped; swap with empty shadow is rejected.
    in_valid = 1'b1;
    in_w     = '1;
    in_psum  = 32'd5;
    tick();
    in_valid = 1'b0;
    probe(P_BUSY, 64'd0, "drop_busy");
    repeat (6) tick();
    do_swap(1'b0, "swap_empty");

    // Basic accumulate and latency.
    load4(32'h04030201);
    do_swap(1'b1, "swap1");
    beat(32'h01010101, 32'd10, 1'b0, 32'd20, 1'b0, "t1");
    probe(P_BUSY, 64'd1, "t1_busy");
    repeat (6) tick();

    // Signed vs unsigned operands.
    load4(32'hFFFFFFFF);
    do_swap(1'b1, "swap2");
    beat(32'h80808080, 32'd0, 1'b1, 32'd512, 1'b0, "t2_signed");
    beat(32'h80808080, 32'd0, 1'b0, 32'd130560, 1'b0, "t2_unsigned");
    repeat (6) tick();
    probe(P_BUSY, 64'd0, "t2_drained");

    // Back-to-back beats with concurrent shadow load.
    for (int i = 0; i < 8; i++) begin
      ld_valid = (i < 4);
      ld_data  = 8'(5 + i);
      beat({4{8'(i + 1)}}, 32'(i), 1'b0, t3_exp[i], 1'b0, "t3_b2b");
    end
    ld_valid = 1'b0;
    probe(P_LDRDY, 64'd0, "t3_shadow_full");
    do_swap(1'b0, "swap_busy");
    repeat (6) tick();
    beat(32'h01010101, 32'd0, 1'b0, 32'd1020, 1'b0, "t3_active_kept");
    repeat (6) tick();
    do_swap(1'b1, "swap3");
    beat(32'h01010101, 32'd0, 1'b0, 32'd26, 1'b0, "t3_new_set");
    repeat (6) tick();

    // Accumulator overflow.
    load4(32'h01010101);
    do_swap(1'b1, "swap4");
    beat(32'h7F7F7F7F, 32'h7FFF_FFF0, 1'b1, t4_exp, t4_ovf, "t4_ovf");
    repeat (6) tick();

    // Reset with beats in flight.
    load4(32'h02020202);
    beat(32'h01010101, 32'd1, 1'b0, 32'd9, 1'b0, "t5_flushed");
    beat(32'h01010101, 32'd2, 1'b0, 32'd10, 1'b0, "t5_flushed");
    rst_n = 1'b0;
    #1;
    probe(P_OVALID, 64'd0, "mid_rst_out_valid");
    probe(P_OPSUM, 64'd0, "mid_rst_out_psum");
    probe(P_BUSY, 64'd0, "mid_rst_busy");
    probe(P_INRDY, 64'd0, "mid_rst_in_ready");
    probe(P_LDRDY, 64'd1, "mid_rst_ld_ready");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    probe(P_SBLEFT, 64'd0, "scoreboard_empty");
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
